// File: rtl/seg_scan_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_pkg
//   Shared constants for the seven-segment scanner:
//     DIGITS        number of multiplexed digits
//     SEG_BLANK     all segments off (active-low)
//     SEG_HEX_0..F  active-low {g,f,e,d,c,b,a} patterns for hex digits
// ---------------------------------------------------------------------------
package seg_scan_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/seg_scan_hex_to_seg.sv
// ---------------------------------------------------------------------------
// seg_scan_hex_to_seg
//   Purely combinational hex-nibble to seven-segment decoder (active-low).
//   Ports:
//     nibble_i  in   4  value to display
//     seg_o     out  7  {g,f,e,d,c,b,a}, 0 = segment lit
// ---------------------------------------------------------------------------
module seg_scan_hex_to_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nibble_i)
      4'h0: seg_o = SEG_HEX_0;
      4'h1: seg_o = SEG_HEX_1;
      4'h2: seg_o = SEG_HEX_2;
      4'h3: seg_o = SEG_HEX_3;
      4'h4: seg_o = SEG_HEX_4;
      4'h5: seg_o = SEG_HEX_5;
      4'h6: seg_o = SEG_HEX_6;
      4'h7: seg_o = SEG_HEX_7;
      4'h8: seg_o = SEG_HEX_8;
      4'h9: seg_o = SEG_HEX_9;
      4'hA: seg_o = SEG_HEX_A;
      4'hB: seg_o = SEG_HEX_B;
      4'hC: seg_o = SEG_HEX_C;
      4'hD: seg_o = SEG_HEX_D;
      4'hE: seg_o = SEG_HEX_E;
      4'hF: seg_o = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan
//   Four-digit multiplexed seven-segment driver. The display word is
//   snapshotted once per scan frame so a frame never mixes old and new
//   nibbles; each digit slot ends with a guard window of all-anodes-off to
//   suppress ghosting.
//   Parameters:
//     DIV_WIDTH  each digit slot lasts 2^DIV_WIDTH clocks
//     GUARD      blank clocks at the end of each slot (< 2^DIV_WIDTH)
//   Ports:
//     clock          in   1   rising-edge clock
//     reset          in   1   asynchronous, active-low
//     data           in   16  display word, digit 0 (rightmost) = data[3:0]
//     displayEnable  in   1   0 blanks the whole display
//     an             out  4   anodes, active-low one-hot
//     seg            out  7   segments {g,f,e,d,c,b,a}, active-low
//     dp             out  1   decimal point, active-low, always off
//     frameTick      out  1   high in the cycle whose closing edge snapshots
//   Build option:
//     SEG_LEADING_ZERO_BLANK_EN  blank digits above the most significant
//                                nonzero nibble (digit 0 always lit)
// ---------------------------------------------------------------------------
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int GUARD     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] data,
  input  logic        displayEnable,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frameTick
);

  localparam int DIGIT_W = $clog2(DIGITS);
  localparam logic [DIV_WIDTH-1:0] DIV_MAX     = '1;
  localparam logic [DIV_WIDTH-1:0] GUARD_START = DIV_WIDTH'((2 ** DIV_WIDTH) - GUARD);
  localparam logic [DIGIT_W-1:0]   LAST_DIGIT  = DIGIT_W'(DIGITS - 1);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIGIT_W-1:0]   digit_q, digit_d;
  logic [15:0]          sh_data_q, sh_data_d;
  logic                 sh_en_q, sh_en_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;

  logic                 tc;
  logic                 frame_end;
  logic                 guard;
  logic                 lz_blank;
  logic                 blank;
  logic [DIGITS-1:0]    an_sel;
  logic [3:0]           nibble;
  logic [6:0]           hex_seg;

  assign tc        = (div_q == DIV_MAX);
  assign frame_end = tc && (digit_q == LAST_DIGIT);
  // GUARD==0 would wrap GUARD_START to 0 and blank everything, so gate it.
  assign guard     = (GUARD > 0) && (div_q >= GUARD_START);

  // One-hot decode of the active slot; shared by the anodes and the
  // leading-zero mask.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_sel
      assign an_sel[gi] = (digit_q == DIGIT_W'(gi));
    end
  endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // lz_mask[i]=1 when nibbles i..top are all zero; digit 0 is never masked.
  logic [DIGITS-1:0] lz_mask;
  assign lz_mask[0] = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_lz
      assign lz_mask[gi] = ~|sh_data_q[4*DIGITS-1:4*gi];
    end
  endgenerate
  assign lz_blank = |(lz_mask & an_sel);
`else
  assign lz_blank = 1'b0;
`endif

  assign nibble = sh_data_q[{digit_q, 2'b00} +: 4];

  seg_scan_hex_to_seg u_hex (
    .nibble_i (nibble),
    .seg_o    (hex_seg)
  );

  // Next-state for counters and the per-frame snapshot.
  always_comb begin
    div_d     = div_q + 1'b1;
    digit_d   = tc ? digit_q + 1'b1 : digit_q;
    sh_data_d = frame_end ? data : sh_data_q;
    sh_en_d   = frame_end ? displayEnable : sh_en_q;
  end

  // Output mux; registered below so outputs lag div/digit by one clock.
  always_comb begin
    blank = guard || !sh_en_q || lz_blank;
    an_d  = blank ? 4'b1111 : ~an_sel;
    seg_d = blank ? SEG_BLANK : hex_seg;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      digit_q   <= '0;
      sh_data_q <= 16'h0000;
      sh_en_q   <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
    end else begin
      div_q     <= div_d;
      digit_q   <= digit_d;
      sh_data_q <= sh_data_d;
      sh_en_q   <= sh_en_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = 1'b1;
  // Decoded from registers only, so it is clean and is 0 while in reset.
  assign frameTick = frame_end;

endmodule

// File: tb/tb_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_scan
//   Scoreboard bench for seg_scan with DIV_WIDTH=3, GUARD=2. The expected
//   anode/segment pair for each upcoming cycle is derived from the elapsed
//   cycle count since reset release and pushed to a queue; it is popped and
//   compared on the following falling edge.
// ---------------------------------------------------------------------------
module tb_seg_scan;

  localparam int DW    = 3;
  localparam int GD    = 2;
  localparam int SLOT  = 8;
  localparam int FRAME = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data = 16'h0000;
  logic        displayEnable = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frameTick;

  always #5 clock = ~clock;

  seg_scan #(.DIV_WIDTH(DW), .GUARD(GD)) dut (
    .clock         (clock),
    .reset         (reset),
    .data          (data),
    .displayEnable (displayEnable),
    .an            (an),
    .seg           (seg),
    .dp            (dp),
    .frameTick     (frameTick)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } out_t;

  out_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          t        = 0;      // cycles since reset release
  int          n_frames = 0;
  logic [15:0] m_sh     = 16'h0000;
  logic        m_en     = 1'b0;
  logic        cur_rst  = 1'b0;
  logic [15:0] cur_d    = 16'h0000;
  logic        cur_en   = 1'b0;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0d, time %0t)", tag, act, exp, t, $time);
    end
  endtask

  function automatic logic [6:0] hex_pat(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // What the outputs register from the state of cycle t.
  function automatic out_t model_out();
    int   p, dg, dv;
    logic blank;
    out_t o;
    p     = t % FRAME;
    dg    = p / SLOT;
    dv    = p % SLOT;
    blank = (dv >= SLOT - GD) || !m_en;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (dg > 0 && (m_sh >> (4 * dg)) == 16'h0000) blank = 1'b1;
`endif
    if (blank) begin
      o.an  = 4'b1111;
      o.seg = 7'b1111111;
    end else begin
      o.an  = ~(4'b0001 << dg);
      o.seg = hex_pat(m_sh[4*dg +: 4]);
    end
    return o;
  endfunction

  // Called on a falling edge: check this cycle, drive the next one.
  task automatic step();
    out_t e;
    if (!reset) begin
      check("rst_an", an, 4'b1111);
      check("rst_seg", seg, 7'b1111111);
      check("rst_tick", frameTick, 1'b0);
    end else begin
      check("frameTick", frameTick, (t % FRAME) == FRAME - 1);
      if (sb_q.size() == 0) begin
        check("sb_empty", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check("an", an, e.an);
        check("seg", seg, e.seg);
      end
    end
    check("dp", dp, 1'b1);

    data          = cur_d;
    displayEnable = cur_en;
    reset         = cur_rst;
    if (!cur_rst) begin
      sb_q.delete();
      t    = 0;
      m_sh = 16'h0000;
      m_en = 1'b0;
    end else begin
      sb_q.push_back(model_out());
      if (t % FRAME == FRAME - 1) begin
        m_sh = cur_d;
        m_en = cur_en;
        n_frames++;
        $display("frame %0d: snapshot data=%h en=%b at t=%0d", n_frames, cur_d, cur_en, t);
      end
      t++;
    end
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int p);
    while (t % FRAME != p) step();
  endtask

  initial begin
    #1 reset = 1'b0;
    @(negedge clock);

    // 1: hold reset with toggling data
    for (int i = 0; i < 5; i++) begin
      cur_d = 16'h1111 * i[15:0];
      step();
    end

    // 2: release with 1234, two frames
    cur_d   = 16'h1234;
    cur_en  = 1'b1;
    cur_rst = 1'b1;
    run(2 * FRAME + 1);

    // 3: change mid-frame
    run_to(12);
    cur_d = 16'hABCD;
    run(2 * FRAME);

    // 4: disable at a boundary, re-enable mid-frame
    run_to(FRAME - 1);
    cur_en = 1'b0;
    run(FRAME + 10);
    cur_en = 1'b1;
    run_to(FRAME - 1);
    run(FRAME + 1);

    // 5: leading zeros
    run_to(FRAME - 1);
    cur_d = 16'h000F;
    run(FRAME + 1);
    run_to(FRAME - 1);
    cur_d = 16'h0000;
    run(FRAME + 1);

    // 6: asynchronous reset while digit 2 is lit
    run_to(FRAME - 1);
    cur_d = 16'h1234;
    run(1);
    run_to(19);
    #2 reset = 1'b0;
    #1;
    check("async_an", an, 4'b1111);
    check("async_seg", seg, 7'b1111111);
    check("async_tick", frameTick, 1'b0);
    @(negedge clock);
    cur_rst = 1'b0;
    step();
    cur_rst = 1'b1;
    run(2 * FRAME + 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
